// File: rtl/priority_encoder_4x2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : priority_encoder_4x2_pkg
// Purpose  : Shared constants, FSM state encoding and helpers for the
//            4-to-2 registered priority encoder with pending/ACK handshake.
// Contents : c_req_w     - number of request lines (4)
//            c_code_w    - width of the served code (2)
//            c_drop_w    - width of the lost-request counter (4)
//            c_drop_max  - saturation value of the lost-request counter (15)
//            state_t     - IDLE (0) / HOLD (1)
//            code_to_onehot - code -> one-hot request mask
// Revision : 1.0 - initial release
// ============================================================================
package priority_encoder_4x2_pkg;

    localparam int c_req_w  = 4;
    localparam int c_code_w = 2;
    localparam int c_drop_w = 4;

    localparam logic [c_drop_w-1:0] c_drop_max = 4'd15;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_hold = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = c_st_idle,
        ST_HOLD = c_st_hold
    } state_t;

    // Mask selecting the request line named by a code.
    function automatic logic [c_req_w-1:0] code_to_onehot(input logic [c_code_w-1:0] code);
        logic [c_req_w-1:0] w_one;
        w_one = {{(c_req_w-1){1'b0}}, 1'b1};
        return w_one << code;
    endfunction

endpackage : priority_encoder_4x2_pkg
`default_nettype wire

// File: rtl/priority_encoder_4x2_if.sv
`default_nettype none
// ============================================================================
// Module   : priority_encoder_4x2_if
// Purpose  : Request/acknowledge bus between a producer/consumer and the
//            priority encoder.
// Signals  : I    [3:0] request lines, I[3] highest priority
//            ACK        consumer acknowledge of the presented code
//            Y    [1:0] code of the served request line (valid while V)
//            V          code valid
//            DROP [3:0] saturating count of cycles with lost requests
// Modports : master - drives I/ACK, observes Y/V/DROP
//            slave  - the encoder side
// Revision : 1.0 - initial release
// ============================================================================
interface priority_encoder_4x2_if;
    import priority_encoder_4x2_pkg::*;

    logic [c_req_w-1:0]  I;
    logic                ACK;
    logic [c_code_w-1:0] Y;
    logic                V;
    logic [c_drop_w-1:0] DROP;

    modport master (
        output I,
        output ACK,
        input  Y,
        input  V,
        input  DROP
    );

    modport slave (
        input  I,
        input  ACK,
        output Y,
        output V,
        output DROP
    );

endinterface : priority_encoder_4x2_if
`default_nettype wire

// File: rtl/priority_encoder_4x2_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc_4x2
// Purpose  : Combinational 4-to-2 priority encoder; bit 3 wins.
// Ports    : i_pend [3:0] pending request vector
//            o_code [1:0] index of highest set bit (00 when none set)
//            o_any        at least one bit of i_pend is set
// Revision : 1.0 - initial release
// ============================================================================
module prio_enc_4x2
    import priority_encoder_4x2_pkg::*;
(
    input  logic [c_req_w-1:0]  i_pend,
    output logic [c_code_w-1:0] o_code,
    output logic                o_any
);

    always_comb begin
        o_code = 2'b00;
        if (i_pend[3]) begin
            o_code = 2'b11;
        end else if (i_pend[2]) begin
            o_code = 2'b10;
        end else if (i_pend[1]) begin
            o_code = 2'b01;
        end
    end

    assign o_any = |i_pend;

endmodule : prio_enc_4x2
`default_nettype wire

// File: rtl/priority_encoder_4x2.sv
`default_nettype none
// ============================================================================
// Module   : priority_encoder_4x2
// Purpose  : Collects request pulses into a pending register and presents
//            them one at a time, highest index first, as a registered code
//            that is held until the consumer acknowledges it.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - slave side of priority_encoder_4x2_if (I, ACK in;
//                   Y, V, DROP out, all outputs registered)
// Revision : 1.0 - initial release
// ============================================================================
module priority_encoder_4x2
    import priority_encoder_4x2_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    priority_encoder_4x2_if.slave  bus
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_req_w-1:0]  r_pend;
    logic [c_code_w-1:0] r_y;
    logic [c_code_w-1:0] w_y_nxt;
    logic                r_v;
    logic                w_v_nxt;
    logic [c_drop_w-1:0] r_drop;

    logic [c_req_w-1:0]  w_clr;
    logic                w_drop_hit;
    logic [c_code_w-1:0] w_code;
    logic                w_any;

    prio_enc_4x2 u_prio_enc (
        .i_pend (r_pend),
        .o_code (w_code),
        .o_any  (w_any)
    );

    // Only an acknowledged, presented code retires its pending bit; ACK
    // with nothing presented has no effect.
    assign w_clr = (r_v && bus.ACK) ? code_to_onehot(r_y) : '0;

    // A request is lost when its line is already pending and is not being
    // retired this cycle. A new request coinciding with the retire simply
    // re-arms the bit.
    assign w_drop_hit = |(bus.I & r_pend & ~w_clr);

    always_comb begin
        w_state_nxt = r_state;
        w_y_nxt     = r_y;
        w_v_nxt     = r_v;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_y_nxt     = w_code;
                    w_v_nxt     = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // The presented code is frozen until acknowledged, even if a
                // higher-priority request arrives meanwhile.
                if (bus.ACK) begin
                    w_v_nxt     = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_v_nxt     = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pend  <= '0;
            r_y     <= '0;
            r_v     <= 1'b0;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= (r_pend & ~w_clr) | bus.I;
            r_y     <= w_y_nxt;
            r_v     <= w_v_nxt;
            if (w_drop_hit && (r_drop != c_drop_max)) begin
                r_drop <= r_drop + 4'd1;
            end
        end
    end

    assign bus.Y    = r_y;
    assign bus.V    = r_v;
    assign bus.DROP = r_drop;

endmodule : priority_encoder_4x2
`default_nettype wire

// File: tb/tb_priority_encoder_4x2.sv
`default_nettype none
// ============================================================================
// Module   : tb_priority_encoder_4x2
// Purpose  : Self-checking bench for priority_encoder_4x2. A table of
//            per-cycle {I, ACK, expected Y, V, DROP} records walks through
//            the handshake cases; hand-written sequences cover DROP
//            saturation, reset during HOLD and restart after reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_priority_encoder_4x2;

    typedef struct {
        logic [3:0] i;
        logic       ack;
        logic [1:0] y;
        logic       v;
        logic [3:0] drop;
    } vec_t;

    localparam int c_nvec = 30;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs [c_nvec];

    priority_encoder_4x2_if bus ();

    priority_encoder_4x2 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] i, input logic ack,
                                input logic [1:0] y, input logic v, input logic [3:0] drop);
        vec_t w_v;
        w_v.i = i; w_v.ack = ack; w_v.y = y; w_v.v = v; w_v.drop = drop;
        return w_v;
    endfunction

    // Apply inputs, take one rising edge, settle before sampling.
    task automatic step(input logic [3:0] i, input logic ack);
        bus.I   = i;
        bus.ACK = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] ey, input logic ev, input logic [3:0] ed);
        checks++;
        if (bus.Y !== ey || bus.V !== ev || bus.DROP !== ed) begin
            errors++;
            $display("FAIL %s: got Y=%b V=%b DROP=%0d, expected Y=%b V=%b DROP=%0d",
                     name, bus.Y, bus.V, bus.DROP, ey, ev, ed);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Single pulse on line 2, held until ACK, then idle with nothing pending.
        vecs[0]  = mk(4'b0100, 1'b0, 2'b00, 1'b0, 4'd0);
        vecs[1]  = mk(4'b0000, 1'b0, 2'b10, 1'b1, 4'd0);
        vecs[2]  = mk(4'b0000, 1'b0, 2'b10, 1'b1, 4'd0);
        vecs[3]  = mk(4'b0000, 1'b1, 2'b10, 1'b0, 4'd0);
        vecs[4]  = mk(4'b0000, 1'b0, 2'b10, 1'b0, 4'd0);
        // Three simultaneous requests with ACK held high; ACK in IDLE ignored.
        vecs[5]  = mk(4'b1011, 1'b1, 2'b10, 1'b0, 4'd0);
        vecs[6]  = mk(4'b0000, 1'b1, 2'b11, 1'b1, 4'd0);
        vecs[7]  = mk(4'b0000, 1'b1, 2'b11, 1'b0, 4'd0);
        vecs[8]  = mk(4'b0000, 1'b1, 2'b01, 1'b1, 4'd0);
        vecs[9]  = mk(4'b0000, 1'b1, 2'b01, 1'b0, 4'd0);
        vecs[10] = mk(4'b0000, 1'b1, 2'b00, 1'b1, 4'd0);
        vecs[11] = mk(4'b0000, 1'b1, 2'b00, 1'b0, 4'd0);
        vecs[12] = mk(4'b0000, 1'b0, 2'b00, 1'b0, 4'd0);
        // No preemption: line 3 arrives while code 00 is held.
        vecs[13] = mk(4'b0001, 1'b0, 2'b00, 1'b0, 4'd0);
        vecs[14] = mk(4'b0000, 1'b0, 2'b00, 1'b1, 4'd0);
        vecs[15] = mk(4'b1000, 1'b0, 2'b00, 1'b1, 4'd0);
        vecs[16] = mk(4'b0000, 1'b0, 2'b00, 1'b1, 4'd0);
        vecs[17] = mk(4'b0000, 1'b1, 2'b00, 1'b0, 4'd0);
        vecs[18] = mk(4'b0000, 1'b0, 2'b11, 1'b1, 4'd0);
        vecs[19] = mk(4'b0000, 1'b1, 2'b11, 1'b0, 4'd0);
        // Re-request coinciding with its own ACK: set wins, no drop.
        vecs[20] = mk(4'b0010, 1'b0, 2'b11, 1'b0, 4'd0);
        vecs[21] = mk(4'b0000, 1'b0, 2'b01, 1'b1, 4'd0);
        vecs[22] = mk(4'b0010, 1'b1, 2'b01, 1'b0, 4'd0);
        vecs[23] = mk(4'b0000, 1'b0, 2'b01, 1'b1, 4'd0);
        vecs[24] = mk(4'b0000, 1'b1, 2'b01, 1'b0, 4'd0);
        // Two lines dropped in one cycle count once.
        vecs[25] = mk(4'b0110, 1'b0, 2'b01, 1'b0, 4'd0);
        vecs[26] = mk(4'b0110, 1'b0, 2'b10, 1'b1, 4'd1);
        vecs[27] = mk(4'b0000, 1'b1, 2'b10, 1'b0, 4'd1);
        vecs[28] = mk(4'b0000, 1'b0, 2'b01, 1'b1, 4'd1);
        vecs[29] = mk(4'b0000, 1'b1, 2'b01, 1'b0, 4'd1);

        // Reset with requests and ACK asserted; reset must win.
        rst = 1'b1;
        bus.I   = 4'b1111;
        bus.ACK = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_state", 2'b00, 1'b0, 4'd0);
        rst = 1'b0;

        for (int k = 0; k < c_nvec; k++) begin
            step(vecs[k].i, vecs[k].ack);
            check($sformatf("vec%0d", k), vecs[k].y, vecs[k].v, vecs[k].drop);
        end

        // Clear DROP, then hold line 2 for 20 cycles without ACK.
        rst = 1'b1;
        step(4'b0000, 1'b0);
        check("reset_clears_drop", 2'b00, 1'b0, 4'd0);
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step(4'b0100, 1'b0);
            check($sformatf("drop_sat_c%0d", k),
                  (k == 1) ? 2'b00 : 2'b10,
                  (k == 1) ? 1'b0  : 1'b1,
                  (k <= 1) ? 4'd0 : ((k - 1 > 15) ? 4'd15 : 4'(k - 1)));
        end

        // Build PEND=1110 while in HOLD with Y=10, then reset mid-HOLD.
        step(4'b1010, 1'b0);
        check("hold_before_reset", 2'b10, 1'b1, 4'd15);
        rst = 1'b1;
        step(4'b1111, 1'b1);
        check("reset_mid_hold", 2'b00, 1'b0, 4'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(4'b0000, 1'b0);
            check($sformatf("no_stale_c%0d", k), 2'b00, 1'b0, 4'd0);
        end

        // First edge after reset release samples I normally.
        rst = 1'b1;
        step(4'b0000, 1'b0);
        rst = 1'b0;
        step(4'b0001, 1'b0);
        check("post_reset_sample", 2'b00, 1'b0, 4'd0);
        step(4'b0000, 1'b0);
        check("post_reset_present", 2'b00, 1'b1, 4'd0);
        step(4'b0000, 1'b1);
        check("post_reset_ack", 2'b00, 1'b0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_priority_encoder_4x2
`default_nettype wire
